// File: rtl/i2c_nios_timer_master.sv
// Avalon-MM initiator that programs an interval timer, services its timeouts and counts ticks.
// Define TIMER_MASTER_SNAP_EN to add a counter snapshot after every serviced tick.
module i2c_nios_timer_master #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned POLL  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      period,
  input  logic             continuous,
  input  logic [CNT_W-1:0] num_ticks,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] tick_count,
  output logic [31:0]      snapshot,
  output logic             snap_valid,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  input  logic             irq
);

  typedef enum logic [3:0] {
    StIdle, StWrPl, StWrPh, StWrCtrl, StWait, StRdSt1, StRdSt2, StWrClr,
    StWrSnap, StRdSnl1, StRdSnl2, StRdSnh1, StRdSnh2, StSettle, StWrStop, StFin
  } state_e;

  localparam logic ItoBit = (POLL == 0);
`ifdef TIMER_MASTER_SNAP_EN
  localparam logic SnapEn = 1'b1;
`else
  localparam logic SnapEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [31:0]      period_q, period_d;
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             abort_pend_q, abort_pend_d;
  logic             cs_q, cs_d, wn_q, wn_d;
  logic [2:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic             accept, stopping;

  assign accept   = (state_q == StIdle) && start;
  assign stopping = abort_pend_q | abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      period_q     <= '0;
      cont_q       <= 1'b0;
      target_q     <= '0;
      tick_q       <= '0;
      abort_pend_q <= 1'b0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      target_q     <= target_d;
      tick_q       <= tick_d;
      abort_pend_q <= abort_pend_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  // Next state; abort is deferred until any in-flight bus cycle has finished.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = (target_d == '0) ? StFin : StWrPl;
      StWrPl:   state_d = stopping ? StWrStop : StWrPh;
      StWrPh:   state_d = stopping ? StWrStop : StWrCtrl;
      StWrCtrl: state_d = stopping ? StWrStop : StWait;
      StWait: begin
        if (stopping)       state_d = StWrStop;
        else if (POLL != 0) state_d = StRdSt1;
        else if (irq)       state_d = StWrClr;
      end
      StRdSt1:  state_d = StRdSt2;
      StRdSt2: begin
        if (stopping)             state_d = StWrStop;
        else if (avm_readdata[0]) state_d = StWrClr;
        else                      state_d = StWait;
      end
      StWrClr: begin
        if (stopping)    state_d = StWrStop;
        else if (SnapEn) state_d = StWrSnap;
        else             state_d = StSettle;
      end
      StWrSnap: state_d = stopping ? StWrStop : StRdSnl1;
      StRdSnl1: state_d = StRdSnl2;
      StRdSnl2: state_d = stopping ? StWrStop : StRdSnh1;
      StRdSnh1: state_d = StRdSnh2;
      StRdSnh2: state_d = stopping ? StWrStop : StSettle;
      StSettle: state_d = (stopping || tick_q == target_q) ? StWrStop : StWait;
      StWrStop: state_d = StFin;
      StFin:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    period_d = period_q;
    cont_d   = cont_q;
    target_d = target_q;
    if (accept) begin
      period_d = period;
      cont_d   = continuous;
      target_d = continuous ? num_ticks : CNT_W'(1);
    end

    abort_pend_d = abort_pend_q;
    if (state_q == StIdle || state_q == StFin) begin
      abort_pend_d = 1'b0;
    end else if (abort && state_q != StWrStop) begin
      abort_pend_d = 1'b1;
    end

    tick_d = tick_q;
    if (accept) begin
      tick_d = '0;
    end else if (state_d == StWrClr && tick_q != target_q) begin
      tick_d = tick_q + 1'b1;
    end
  end

  // Bus and status outputs are registered, so they are decoded from the next state.
  always_comb begin
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      StWrPl:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = period_d[15:0];  end
      StWrPh:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = period_d[31:16]; end
      StWrCtrl: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = 3'd1;
        wdata_d = 16'h0004 | {14'd0, cont_d, ItoBit};
      end
      StRdSt1, StRdSt2:   begin cs_d = 1'b1; addr_d = 3'd0; end
      StWrClr:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
      StWrSnap: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
      StRdSnl1, StRdSnl2: begin cs_d = 1'b1; addr_d = 3'd4; end
      StRdSnh1, StRdSnh2: begin cs_d = 1'b1; addr_d = 3'd5; end
      StWrStop: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008; end
      default:  ;
    endcase
    busy_d    = (state_d != StIdle) && (state_d != StFin);
    done_d    = (state_d == StFin);
    aborted_d = (state_d == StFin) && abort_pend_q;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign tick_count     = tick_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;

`ifdef TIMER_MASTER_SNAP_EN
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic        snap_valid_q, snap_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_lo_q    <= '0;
      snapshot_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_lo_q    <= snap_lo_d;
      snapshot_q   <= snapshot_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  always_comb begin
    snap_lo_d    = snap_lo_q;
    snapshot_d   = snapshot_q;
    snap_valid_d = 1'b0;
    if (state_q == StRdSnl2) snap_lo_d = avm_readdata;
    if (state_q == StRdSnh2) begin
      snapshot_d   = {avm_readdata, snap_lo_q};
      snap_valid_d = 1'b1;
    end
  end

  assign snapshot   = snapshot_q;
  assign snap_valid = snap_valid_q;
`else
  // Only the status TO bit is consumed when snapshots are compiled out.
  logic unused_rdata;
  assign unused_rdata = ^avm_readdata[15:1];
  assign snapshot     = '0;
  assign snap_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_nios_timer_master.sv
// Bench: two timer-master instances (irq-driven and polling), each on a behavioural interval
// timer slave; runs are scored against a transaction-level model of the expected bus traffic.
module tb_i2c_nios_timer_master;
  localparam int unsigned CNT_W = 16;
`ifdef TIMER_MASTER_SNAP_EN
  localparam bit SnapEn = 1'b1;
`else
  localparam bit SnapEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start, abort, continuous, irq_force;
  logic [31:0]      period;
  logic [CNT_W-1:0] num_ticks;
  int               sel;
  int               cyc = 0;
  int               n_assert = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_sys
    logic             busy, done, aborted, snap_valid, cs, wn, irq;
    logic [CNT_W-1:0] tick_count;
    logic [31:0]      snapshot, cnt, snap_r;
    logic [2:0]       addr;
    logic [15:0]      wdata, rdata, per_lo, per_hi, rd_mux;
    logic             to, run, ito, cont_r, irq_r;

    i2c_nios_timer_master #(.CNT_W(CNT_W), .POLL(g)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start && sel == g),
      .abort         (abort && sel == g),
      .period        (period),
      .continuous    (continuous),
      .num_ticks     (num_ticks),
      .busy          (busy),
      .done          (done),
      .aborted       (aborted),
      .tick_count    (tick_count),
      .snapshot      (snapshot),
      .snap_valid    (snap_valid),
      .avm_address   (addr),
      .avm_chipselect(cs),
      .avm_write_n   (wn),
      .avm_writedata (wdata),
      .avm_readdata  (rdata),
      .irq           (irq)
    );

    assign irq = irq_r | (irq_force & (g == 1));

    always_comb begin
      case (addr)
        3'd0:    rd_mux = {14'd0, run, to};
        3'd1:    rd_mux = {14'd0, cont_r, ito};
        3'd2:    rd_mux = per_lo;
        3'd3:    rd_mux = per_hi;
        3'd4:    rd_mux = snap_r[15:0];
        3'd5:    rd_mux = snap_r[31:16];
        default: rd_mux = 16'h0;
      endcase
    end

    // Interval timer slave: timeout every period+1 clocks, one-shot stops at zero.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        per_lo <= '0; per_hi <= '0; cnt <= '0; snap_r <= '0; rdata <= '0;
        to <= 1'b0; run <= 1'b0; ito <= 1'b0; cont_r <= 1'b0; irq_r <= 1'b0;
      end else begin
        rdata <= (cs && wn) ? rd_mux : 16'h0;
        irq_r <= to & ito;
        if (run) begin
          if (cnt == 0) begin
            to <= 1'b1;
            if (cont_r) cnt <= {per_hi, per_lo};
            else run <= 1'b0;
          end else begin
            cnt <= cnt - 1;
          end
        end
        if (cs && !wn) begin
          case (addr)
            3'd0: if (!(run && cnt == 0)) to <= 1'b0;
            3'd1: begin
              ito    <= wdata[0];
              cont_r <= wdata[1];
              if (wdata[3]) run <= 1'b0;
              else if (wdata[2]) begin
                run <= 1'b1;
                cnt <= {per_hi, per_lo};
              end
            end
            3'd2: per_lo <= wdata;
            3'd3: per_hi <= wdata;
            3'd4: snap_r <= cnt;
            default: ;
          endcase
        end
      end
    end
  end

  logic             m_busy, m_done, m_aborted, m_snapv, m_cs, m_wn;
  logic [CNT_W-1:0] m_tick;
  logic [31:0]      m_snapshot;
  logic [2:0]       m_addr;
  logic [15:0]      m_wdata;

  always_comb begin
    if (sel == 1) begin
      m_busy = g_sys[1].busy; m_done = g_sys[1].done; m_aborted = g_sys[1].aborted;
      m_snapv = g_sys[1].snap_valid; m_cs = g_sys[1].cs; m_wn = g_sys[1].wn;
      m_tick = g_sys[1].tick_count; m_snapshot = g_sys[1].snapshot;
      m_addr = g_sys[1].addr; m_wdata = g_sys[1].wdata;
    end else begin
      m_busy = g_sys[0].busy; m_done = g_sys[0].done; m_aborted = g_sys[0].aborted;
      m_snapv = g_sys[0].snap_valid; m_cs = g_sys[0].cs; m_wn = g_sys[0].wn;
      m_tick = g_sys[0].tick_count; m_snapshot = g_sys[0].snapshot;
      m_addr = g_sys[0].addr; m_wdata = g_sys[0].wdata;
    end
  end

  // Bus monitor: sole writer of the logs, sampled on the falling edge.
  int wr_a[$];
  int wr_d[$];
  int wr_c[$];
  int rd_cnt[8];
  int cs_cnt = 0;
  int snapv_cnt = 0;
  int bad_wn = 0;
  initial for (int i = 0; i < 8; i++) rd_cnt[i] = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (m_cs) cs_cnt <= cs_cnt + 1;
      if (m_cs && !m_wn) begin
        wr_a.push_back(int'(m_addr));
        wr_d.push_back(int'(m_wdata));
        wr_c.push_back(cyc);
      end
      if (m_cs && m_wn) rd_cnt[m_addr] <= rd_cnt[m_addr] + 1;
      if (!m_cs && !m_wn) bad_wn <= bad_wn + 1;
      if (m_snapv) snapv_cnt <= snapv_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, m_busy, 0);
    chk({tag, " done"}, m_done, 0);
    chk({tag, " aborted"}, m_aborted, 0);
    chk({tag, " tick"}, m_tick, 0);
    chk({tag, " cs"}, m_cs, 0);
    chk({tag, " write_n"}, m_wn, 1);
    chk({tag, " addr"}, m_addr, 0);
    chk({tag, " wdata"}, m_wdata, 0);
    chk({tag, " snap_valid"}, m_snapv, 0);
    chk({tag, " snapshot"}, m_snapshot, 0);
  endtask

  // One run: model the expected transaction list from the rules, drive it, compare.
  task automatic run(input int s, input logic [31:0] p, input bit c, input int n,
                     input int abort_at, input int budget, input string nm);
    int ex_a[$];
    int ex_d[$];
    int clr[$];
    int tgt, ticks, nsnap, s_cyc, d_cyc, ab_cyc, wb, csb, svb, r0, r4, r5, nw;
    bit got, ab_sent, exp_ab;
    logic got_ab;
    logic [CNT_W-1:0] got_tick;

    tgt    = c ? n : 1;
    exp_ab = (abort_at > 0) && (abort_at <= tgt);
    ticks  = exp_ab ? abort_at : tgt;
    nsnap  = 0;
    if (tgt != 0) begin
      ex_a.push_back(2); ex_d.push_back(int'(p[15:0]));
      ex_a.push_back(3); ex_d.push_back(int'(p[31:16]));
      ex_a.push_back(1); ex_d.push_back(4 + (c ? 2 : 0) + (s == 0 ? 1 : 0));
      for (int t = 1; t <= ticks; t++) begin
        ex_a.push_back(0); ex_d.push_back(0);
        if (SnapEn && !(exp_ab && t == ticks)) begin
          ex_a.push_back(4); ex_d.push_back(0); nsnap++;
        end
      end
      ex_a.push_back(1); ex_d.push_back(8);
    end

    @(negedge clk);
    sel = s;
    #1;
    wb = wr_a.size(); csb = cs_cnt; svb = snapv_cnt;
    r0 = rd_cnt[0]; r4 = rd_cnt[4]; r5 = rd_cnt[5];
    period = p; continuous = c; num_ticks = CNT_W'(n); start = 1'b1;
    s_cyc = cyc;
    got = 0; ab_sent = 0; d_cyc = 0; ab_cyc = 0; got_ab = 0; got_tick = '0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_done) begin
        got = 1; d_cyc = cyc; got_ab = m_aborted; got_tick = m_tick;
      end else if (abort_at > 0 && !ab_sent && m_busy && int'(m_tick) == abort_at) begin
        abort = 1'b1; ab_sent = 1; ab_cyc = cyc;
      end else begin
        abort = 1'b0;
      end
    end
    abort = 1'b0;
    @(negedge clk);
    #1;

    chk({nm, " done seen"}, got, 1);
    chk({nm, " aborted"}, got_ab, exp_ab);
    chk({nm, " tick_count"}, got_tick, ticks);
    chk({nm, " busy after done"}, m_busy, 0);
    nw = wr_a.size() - wb;
    chk({nm, " write count"}, nw, ex_a.size());
    for (int i = 0; i < nw && i < ex_a.size(); i++) begin
      chk($sformatf("%s write %0d addr/data", nm, i), {wr_a[wb+i], wr_d[wb+i]},
          {ex_a[i], ex_d[i]});
      if (wr_a[wb+i] == 0) clr.push_back(wr_c[wb+i]);
    end
    if (s == 0 && c) begin
      for (int i = 1; i < clr.size(); i++)
        chk($sformatf("%s clear spacing %0d", nm, i), clr[i] - clr[i-1], p + 1);
    end
    chk({nm, " status polled"}, (rd_cnt[0] - r0) > 0, (s == 1) && (tgt != 0));
    chk({nm, " status reads whole"}, (rd_cnt[0] - r0) % 2, 0);
    chk({nm, " snapshot reads"}, (rd_cnt[4] - r4) + (rd_cnt[5] - r5), 4 * nsnap);
    chk({nm, " snap_valid pulses"}, snapv_cnt - svb, nsnap);
    if (tgt == 0) begin
      chk({nm, " done latency"}, d_cyc - s_cyc, 1);
      chk({nm, " no chipselect"}, cs_cnt - csb, 0);
    end
    if (exp_ab && nw > 0) chk({nm, " stop within 3 clk"}, (wr_c[wb+nw-1] - ab_cyc) <= 3, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; period = '0; continuous = 1'b0;
    num_ticks = '0; irq_force = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("reset");
    reset = 1'b0;

    run(0, 32'd9, 1'b1, 3, -1, 200, "t1 cont3");
    run(0, 32'd4, 1'b0, 7, -1, 100, "t2 oneshot");
    run(0, 32'd50, 1'b1, 0, -1, 20, "t3 zero");
    run(0, 32'd99, 1'b1, 10, 2, 800, "t4 abort");
    run(0, 32'd6, 1'b0, 1, 1, 100, "t4 abort last");

    // Reset while waiting for the first timeout of a long run.
    @(negedge clk);
    sel = 0; period = 32'd99; continuous = 1'b1; num_ticks = CNT_W'(10); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && m_tick != 1; i++) @(negedge clk);
    chk("rst tick before reset", m_tick, 1);
    repeat (5) @(negedge clk);
    chk("rst busy in wait", m_busy, 1);
    reset = 1'b1;
    #1;
    chk_reset("rst mid-wait");
    @(negedge clk);
    reset = 1'b0;
    begin
      int csb;
      #1;
      csb = cs_cnt;
      repeat (150) @(negedge clk);
      #1;
      chk("rst quiet after reset", cs_cnt - csb, 0);
      chk("rst idle after reset", m_busy, 0);
    end

    irq_force = 1'b1;
    run(1, 32'd20, 1'b1, 2, -1, 300, "t5 poll");
    irq_force = 1'b0;

    for (int r = 0; r < 6; r++) begin
      int rs, rn, ra, rt;
      logic [31:0] rp;
      bit rc;
      rs = int'($urandom_range(1, 0));
      rp = $urandom_range(40, 12);
      rc = bit'($urandom_range(1, 0));
      rn = int'($urandom_range(5, 0));
      rt = rc ? rn : 1;
      ra = -1;
      if (rt > 0 && $urandom_range(2, 0) == 0) ra = int'($urandom_range(rt, 1));
      run(rs, rp, rc, rn, ra, 60 * (rt + 2) + 40, $sformatf("rand%0d", r));
    end

    run(0, 32'h0001_0005, 1'b0, 3, -1, 70000, "t6 snap");
    chk("t6 snapshot value", m_snapshot, 0);
    chk("write_n only with chipselect", bad_wn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_nios_timer_master.md
Name: i2c_nios_timer_master

Overview:
Avalon-MM initiator that drives the system's 16-bit-data interval timer slave without a CPU. On a start request it:
- programs the 32-bit period and starts the timer (one-shot or continuous);
- services each timeout, by IRQ or by polling, and counts ticks;
- stops the timer after N ticks, or when aborted.

It lets the I2C sequencing fabric get hardware delays without Nios intervention.

Parameters:
CNT_W, 16, width of num_ticks and tick_count.
POLL, 0, 0 = wait on irq input (ITO=1); 1 = poll status register via reads (ITO=0).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request pulse; ignored while busy
abort  in  1  stop current run; ignored when idle
period  in  32  timer period value P (tick every P+1 clk)
continuous  in  1  1 = continuous, 0 = one-shot
num_ticks  in  CNT_W  ticks to count in continuous mode
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
aborted  out  1  valid with done; 1 if run ended by abort
tick_count  out  CNT_W  ticks serviced in current/last run
snapshot  out  32  last counter snapshot (optional feature)
snap_valid  out  1  one-cycle pulse when snapshot updates
avm_address  out  3  timer register word address
avm_chipselect  out  1  slave select
avm_write_n  out  1  active-low write
avm_writedata  out  16  write data
avm_readdata  in  16  slave read data (slave-registered)
irq  in  1  timer interrupt

Behaviour:
- Reset values:
  - busy, done, aborted, snap_valid, avm_chipselect, avm_address, avm_writedata, tick_count, snapshot = 0.
  - avm_write_n = 1.
- All avm_* outputs are registered.
- Reset mid-run returns the block to IDLE immediately. No stop write is issued.
- Write cycle: chipselect=1, write_n=0 for exactly 1 clk. The slave has no waitrequest.
- Read cycle: chipselect=1, write_n=1, address held 2 clk. readdata is sampled at the end of the second cycle (slave read latency 1 registered stage).
- Between bus accesses: chipselect=0, write_n=1.
- On start, the block captures:
  - period, continuous, num_ticks;
  - target = continuous ? num_ticks : 1.
  - tick_count is cleared.
- If target == 0, the block pulses done 1 clk after start with no bus activity and tick_count 0.
- Otherwise the FSM runs:
  - IDLE -> WR_PL (addr 2, period[15:0]) -> WR_PH (addr 3, period[31:16]) -> WR_CTRL (addr 1, data = 0x0004 | continuous<<1 | ~POLL) -> WAIT.
  - WAIT, POLL=0: wait for irq=1.
  - WAIT, POLL=1: repeated 2-cycle reads of addr 0, exit when readdata[0]=1.
  - WAIT -> WR_CLR (addr 0, data 0) -> SETTLE (1 idle clk; irq is not sampled here because the slave clears it one clk after the write).
  - At WR_CLR: tick_count += 1.
  - SETTLE: if tick_count == target -> WR_STOP, else -> WAIT.
  - WR_STOP (addr 1, data 0x0008) -> FIN (done=1, busy=0) -> IDLE.
- tick_count saturates: it never exceeds target.
- abort in any non-IDLE state:
  - Any bus cycle already in flight completes.
  - Then WR_STOP, FIN with aborted=1.
  - abort in the same cycle as the final tick clear: the stop write is issued once and aborted=1 (abort has priority).
- start and abort asserted together while idle: start is accepted and abort is ignored.
- busy rises the clk after start is accepted.

Optional Feature:
TIMER_MASTER_SNAP_EN:
- With the macro defined, after each WR_CLR the block runs:
  - WR_SNAP (addr 4, data 0);
  - RD_SNL (read addr 4);
  - RD_SNH (read addr 5).
- The block then sets snapshot = {hi, lo}, pulses snap_valid for 1 clk, and moves to SETTLE.
- Without the macro, snapshot = 0, snap_valid = 0, and no addr 4/5 accesses are ever issued.

Test Plan:
1. With the bench connected to the team's Avalon interval timer core, POLL=0, P=9, continuous=1, num_ticks=3 -> bus writes are a2=0x0009, a3=0x0000, a1=0x0007. Three status clears to a0 follow, spaced 10 clk apart. Then a1=0x0008, done pulse, tick_count=3, aborted=0.
2. One-shot, P=4, num_ticks=7 -> exactly one a0 clear, then stop write, tick_count=1.
3. num_ticks=0, continuous=1 -> done 1 clk after start, no chipselect ever asserted, tick_count=0.
4. Run P=99, continuous, num_ticks=10. Assert abort after the 2nd tick -> stop write a1=0x0008 within 3 clk, done with aborted=1, tick_count=2. Assert reset mid-WAIT -> all outputs return to reset values.
5. POLL=1, P=20, continuous, num_ticks=2 -> control write 0x0006, read loops on addr 0, tick_count=2, irq ignored.
6. With TIMER_MASTER_SNAP_EN defined, P=0x0001_0005, one-shot -> a4 write, reads a4/a5, snap_valid=1 once with snapshot==0. Without the macro -> no addr 4/5 accesses and snap_valid stays 0.
